// File: rtl/xif_commit_scheduler.sv
// xif_commit_scheduler: in-order queue of accepted XIF offloads, released to the FPU once committed.
// Killed heads are discarded; commits that arrive before their issue wait in an early-commit register.
module xif_commit_scheduler #(
    parameter int QUEUE_DEPTH = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int XLEN        = 32,
    parameter int X_NUM_RS    = 3
) (
    input  logic                         ck,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [X_ID_WIDTH-1:0]        in_id,
    input  logic [31:0]                  in_instr,
    input  logic [X_NUM_RS*XLEN-1:0]     in_rs,
    input  logic [1:0]                   in_mode,
    input  logic                         commit_valid,
    input  logic [X_ID_WIDTH-1:0]        commit_id,
    input  logic                         commit_kill,
    output logic                         disp_valid,
    input  logic                         disp_ready,
    output logic [X_ID_WIDTH-1:0]        disp_id,
    output logic [31:0]                  disp_instr,
    output logic [X_NUM_RS*XLEN-1:0]     disp_rs,
    output logic [1:0]                   disp_mode,
    output logic [$clog2(QUEUE_DEPTH):0] count,
    output logic                         early_pending,
    output logic                         kill_drop
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = X_NUM_RS * XLEN;

    logic [QUEUE_DEPTH-1:0] v_q, c_q, k_q, hit;
    logic [X_ID_WIDTH-1:0]  id_q [QUEUE_DEPTH];
    logic [31:0]            instr_q [QUEUE_DEPTH];
    logic [RW-1:0]          rs_q [QUEUE_DEPTH];
    logic [1:0]             mode_q [QUEUE_DEPTH];
    logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [X_ID_WIDTH-1:0]  early_id_q, early_id_d;
    logic                   early_v_q, early_v_d, early_k_q, early_k_d, kill_drop_q;
    logic                   drop, pop, enq, seen, new_cm, early_hit, st_early;

    // Any valid entry with this ID claims the commit; an already-committed one swallows it.
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++)
            hit[i] = commit_valid && v_q[i] && id_q[i] == commit_id;
    end

    assign in_ready   = enable && cnt_q < CW'(QUEUE_DEPTH);
    assign disp_valid = enable && v_q[rd_q] && c_q[rd_q] && !k_q[rd_q];
    assign drop       = enable && v_q[rd_q] && c_q[rd_q] && k_q[rd_q];
    assign pop        = drop || (disp_valid && disp_ready);
    assign enq        = in_valid && in_ready;
    assign seen       = |hit;
    assign new_cm     = commit_valid && !seen && in_id == commit_id;
    assign early_hit  = early_v_q && early_id_q == in_id;
    assign st_early   = commit_valid && !seen && !(enq && in_id == commit_id);
    assign rd_d       = pop ? rd_q + PW'(1) : rd_q;
    assign wr_d       = enq ? wr_q + PW'(1) : wr_q;
    assign cnt_d      = cnt_q + CW'(enq) - CW'(pop);
    assign early_v_d  = st_early || (early_v_q && !(enq && early_hit));
    assign early_id_d = st_early ? commit_id : early_id_q;
    assign early_k_d  = st_early ? commit_kill : early_k_q;

    assign disp_id       = id_q[rd_q];
    assign disp_instr    = instr_q[rd_q];
    assign disp_rs       = rs_q[rd_q];
    assign disp_mode     = mode_q[rd_q];
    assign count         = cnt_q;
    assign early_pending = early_v_q;
    assign kill_drop     = kill_drop_q;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            v_q         <= '0;
            c_q         <= '0;
            k_q         <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            early_v_q   <= 1'b0;
            early_k_q   <= 1'b0;
            early_id_q  <= '0;
            kill_drop_q <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                id_q[i]    <= '0;
                instr_q[i] <= '0;
                rs_q[i]    <= '0;
                mode_q[i]  <= '0;
            end
        end else if (enable) begin
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            early_v_q   <= early_v_d;
            early_id_q  <= early_id_d;
            early_k_q   <= early_k_d;
            kill_drop_q <= drop;
            for (int i = 0; i < QUEUE_DEPTH; i++)
                if (hit[i] && !c_q[i]) begin
                    c_q[i] <= 1'b1;
                    k_q[i] <= commit_kill;
                end
            if (pop)
                v_q[rd_q] <= 1'b0;
            if (enq) begin
                v_q[wr_q]     <= 1'b1;
                c_q[wr_q]     <= new_cm || early_hit;
                k_q[wr_q]     <= new_cm ? commit_kill : early_hit && early_k_q;
                id_q[wr_q]    <= in_id;
                instr_q[wr_q] <= in_instr;
                rs_q[wr_q]    <= in_rs;
                mode_q[wr_q]  <= in_mode;
            end
        end
    end
endmodule

// File: tb/tb_xif_commit_scheduler.sv
// tb_xif_commit_scheduler: directed vector table, async-reset sequence and randomized run
// against a queue-based reference model of the commit scheduler.
module tb_xif_commit_scheduler;
    localparam int D  = 4;
    localparam int IW = 4;
    localparam int RW = 3 * 32;

    logic          ck = 1'b0, rst = 1'b1, enable = 1'b0;
    logic          in_valid = 1'b0, commit_valid = 1'b0, commit_kill = 1'b0, disp_ready = 1'b0;
    logic [IW-1:0] in_id = '0, commit_id = '0;
    logic [31:0]   in_instr = '0;
    logic [RW-1:0] in_rs = '0;
    logic [1:0]    in_mode = '0;
    logic          in_ready, disp_valid, early_pending, kill_drop;
    logic [IW-1:0] disp_id;
    logic [31:0]   disp_instr;
    logic [RW-1:0] disp_rs;
    logic [1:0]    disp_mode;
    logic [2:0]    count;

    int n_tests = 0;
    int n_fail  = 0;

    xif_commit_scheduler dut (
        .ck(ck), .rst(rst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_instr(in_instr),
        .in_rs(in_rs), .in_mode(in_mode),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_id(disp_id),
        .disp_instr(disp_instr), .disp_rs(disp_rs), .disp_mode(disp_mode),
        .count(count), .early_pending(early_pending), .kill_drop(kill_drop)
    );

    always #5 ck = ~ck;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [IW-1:0] id);
        return id == 4'd3 ? 32'h0020F053 : 32'h1000_0000 | 32'(id);
    endfunction

    function automatic logic [RW-1:0] rs_of(input logic [IW-1:0] id);
        return {32'h3000_0000 | 32'(id), 32'h2000_0000 | 32'(id), 32'h1000_0000 | 32'(id)};
    endfunction

    typedef struct {
        bit en, iv; logic [IW-1:0] iid;
        bit cv; logic [IW-1:0] cid; bit kl; bit dr;
        bit e_ir, e_dv; logic [IW-1:0] e_id; int e_cnt; bit e_ep, e_kd;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(bit en, bit iv, int iid, bit cv, int cid, bit kl, bit dr,
                               bit e_ir, bit e_dv, int e_id, int e_cnt, bit e_ep, bit e_kd);
        vec_t r;
        r.en = en; r.iv = iv; r.iid = IW'(iid); r.cv = cv; r.cid = IW'(cid); r.kl = kl; r.dr = dr;
        r.e_ir = e_ir; r.e_dv = e_dv; r.e_id = IW'(e_id); r.e_cnt = e_cnt; r.e_ep = e_ep; r.e_kd = e_kd;
        return r;
    endfunction

    task automatic apply(input vec_t r, input int n);
        enable = r.en; in_valid = r.iv; in_id = r.iid; in_instr = instr_of(r.iid);
        in_rs = rs_of(r.iid); in_mode = r.iid[1:0];
        commit_valid = r.cv; commit_id = r.cid; commit_kill = r.kl; disp_ready = r.dr;
        @(negedge ck);
        chk($sformatf("row%0d in_ready", n), in_ready, r.e_ir);
        chk($sformatf("row%0d disp_valid", n), disp_valid, r.e_dv);
        chk($sformatf("row%0d count", n), count, r.e_cnt);
        chk($sformatf("row%0d early_pending", n), early_pending, r.e_ep);
        chk($sformatf("row%0d kill_drop", n), kill_drop, r.e_kd);
        if (r.e_dv) begin
            chk($sformatf("row%0d disp_id", n), disp_id, r.e_id);
            chk($sformatf("row%0d disp_instr", n), disp_instr, instr_of(r.e_id));
            chk($sformatf("row%0d disp_rs", n), disp_rs, rs_of(r.e_id));
        end
        @(posedge ck); #1;
    endtask

    task automatic idle();
        in_valid = 0; commit_valid = 0; commit_kill = 0;
    endtask

    typedef struct {
        logic [IW-1:0] id; logic [31:0] instr; logic [RW-1:0] rs; logic [1:0] mode; bit c, k;
    } ent_t;
    ent_t mq[$];
    bit            m_ev, m_ek, m_kd;
    logic [IW-1:0] m_eid;

    task automatic check_model(input int n);
        bit dv;
        dv = enable && mq.size() > 0 && mq[0].c && !mq[0].k;
        chk($sformatf("rnd%0d in_ready", n), in_ready, enable && mq.size() < D);
        chk($sformatf("rnd%0d disp_valid", n), disp_valid, dv);
        chk($sformatf("rnd%0d count", n), count, mq.size());
        chk($sformatf("rnd%0d early_pending", n), early_pending, m_ev);
        chk($sformatf("rnd%0d kill_drop", n), kill_drop, m_kd);
        if (dv) begin
            chk($sformatf("rnd%0d disp_id", n), disp_id, mq[0].id);
            chk($sformatf("rnd%0d disp_instr", n), disp_instr, mq[0].instr);
            chk($sformatf("rnd%0d disp_rs", n), disp_rs, mq[0].rs);
            chk($sformatf("rnd%0d disp_mode", n), disp_mode, mq[0].mode);
        end
    endtask

    task automatic model_step();
        ent_t ne;
        int   f;
        bit   drop, pop, enq, ehit;
        if (!enable) return;
        drop = mq.size() > 0 && mq[0].c && mq[0].k;
        pop  = drop || (mq.size() > 0 && mq[0].c && !mq[0].k && disp_ready);
        enq  = in_valid && mq.size() < D;
        ne.id = in_id; ne.instr = in_instr; ne.rs = in_rs; ne.mode = in_mode;
        ehit = enq && m_ev && m_eid == in_id;
        ne.c = ehit;
        ne.k = ehit && m_ek;
        if (ehit) m_ev = 0;
        if (commit_valid) begin
            f = -1;
            foreach (mq[i]) if (mq[i].id == commit_id) f = i;
            if (f >= 0) begin
                if (!mq[f].c) begin
                    mq[f].c = 1;
                    mq[f].k = commit_kill;
                end
            end else if (enq && in_id == commit_id) begin
                ne.c = 1;
                ne.k = commit_kill;
            end else begin
                m_ev = 1; m_eid = commit_id; m_ek = commit_kill;
            end
        end
        m_kd = drop;
        if (pop) void'(mq.pop_front());
        if (enq) mq.push_back(ne);
    endtask

    initial begin
        #1 rst = 0;
        #1;
        chk("reset in_ready", in_ready, 1'b0);
        enable = 1;
        #1;
        chk("reset in_ready en", in_ready, 1'b1);
        chk("reset disp_valid", disp_valid, 1'b0);
        chk("reset count", count, 0);
        chk("reset early_pending", early_pending, 1'b0);
        chk("reset kill_drop", kill_drop, 1'b0);
        chk("reset disp_instr", disp_instr, 0);
        @(posedge ck); #1 rst = 1;

        // en iv iid cv cid kl dr | ir dv id cnt ep kd
        tbl.push_back(v(1,1,3, 0,0,0, 1, 1,0,0, 0,0,0));
        tbl.push_back(v(1,0,0, 1,3,0, 1, 1,0,0, 1,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,1,3, 1,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,0,0, 0,0,0));
        tbl.push_back(v(1,0,0, 1,5,0, 1, 1,0,0, 0,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,0,0, 0,1,0));
        tbl.push_back(v(1,1,5, 0,0,0, 1, 1,0,0, 0,1,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,1,5, 1,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,0,0, 0,0,0));
        tbl.push_back(v(1,1,1, 0,0,0, 1, 1,0,0, 0,0,0));
        tbl.push_back(v(1,1,2, 0,0,0, 1, 1,0,0, 1,0,0));
        tbl.push_back(v(1,0,0, 1,1,1, 1, 1,0,0, 2,0,0));
        tbl.push_back(v(1,0,0, 1,2,0, 1, 1,0,0, 2,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,1,2, 1,0,1));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,0,0, 0,0,0));
        tbl.push_back(v(1,1,7, 0,0,0, 1, 1,0,0, 0,0,0));
        tbl.push_back(v(1,1,8, 1,8,0, 1, 1,0,0, 1,0,0));
        tbl.push_back(v(1,0,0, 1,7,0, 1, 1,0,0, 2,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,1,7, 2,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,1,8, 1,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,0,0, 0,0,0));
        tbl.push_back(v(1,1,0, 1,0,0, 0, 1,0,0, 0,0,0));
        tbl.push_back(v(1,1,1, 1,1,0, 0, 1,1,0, 1,0,0));
        tbl.push_back(v(1,1,2, 1,2,0, 0, 1,1,0, 2,0,0));
        tbl.push_back(v(1,1,3, 1,3,0, 0, 1,1,0, 3,0,0));
        tbl.push_back(v(1,1,9, 0,0,0, 0, 0,1,0, 4,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 0,1,0, 4,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,1,1, 3,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,1,2, 2,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,1,3, 1,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,0,0, 0,0,0));
        tbl.push_back(v(0,1,4, 1,4,0, 1, 0,0,0, 0,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,0,0, 0,0,0));
        tbl.push_back(v(1,0,0, 1,6,1, 1, 1,0,0, 0,0,0));
        tbl.push_back(v(1,0,0, 1,9,0, 1, 1,0,0, 0,1,0));
        tbl.push_back(v(1,1,6, 0,0,0, 1, 1,0,0, 0,1,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,0,0, 1,1,0));
        tbl.push_back(v(1,0,0, 1,6,1, 1, 1,0,0, 1,1,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,0,0, 1,1,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,0,0, 0,1,1));
        tbl.push_back(v(1,1,9, 0,0,0, 1, 1,0,0, 0,1,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,1,9, 1,0,0));
        tbl.push_back(v(1,0,0, 0,0,0, 1, 1,0,0, 0,0,0));
        foreach (tbl[i]) apply(tbl[i], i);

        // Asynchronous reset with three queued entries and a pending early commit.
        enable = 1; disp_ready = 1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1; in_id = IW'(i); in_instr = instr_of(IW'(i));
            commit_valid = (i == 1); commit_id = 4'd12; commit_kill = 0;
            @(posedge ck); #1;
        end
        idle();
        @(negedge ck);
        chk("pre-reset count", count, 3);
        chk("pre-reset early_pending", early_pending, 1'b1);
        #2 rst = 0;
        #1;
        chk("async reset count", count, 0);
        chk("async reset in_ready", in_ready, 1'b1);
        chk("async reset disp_valid", disp_valid, 1'b0);
        chk("async reset early_pending", early_pending, 1'b0);
        @(posedge ck); #1 rst = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge ck);
            chk("post-reset count", count, 0);
            chk("post-reset disp_valid", disp_valid, 1'b0);
        end
        @(posedge ck); #1;

        mq.delete(); m_ev = 0; m_ek = 0; m_kd = 0; m_eid = '0;
        for (int n = 0; n < 3000; n++) begin
            enable = $urandom_range(0, 9) != 0;
            in_valid = $urandom_range(0, 1) == 1;
            in_id = IW'($urandom_range(0, 15));
            foreach (mq[i]) if (mq[i].id == in_id) in_valid = 0;
            in_instr = $urandom;
            in_rs = {$urandom, $urandom, $urandom};
            in_mode = 2'($urandom_range(0, 3));
            commit_valid = $urandom_range(0, 9) < 4;
            commit_id = (mq.size() > 0 && $urandom_range(0, 1) == 1) ?
                        mq[$urandom_range(0, mq.size() - 1)].id : IW'($urandom_range(0, 15));
            commit_kill = $urandom_range(0, 3) == 0;
            disp_ready = $urandom_range(0, 9) < 7;
            @(negedge ck);
            check_model(n);
            model_step();
            @(posedge ck); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
